// File: rtl/vpu_cmd_queue.sv
// rtl/vpu_cmd_queue.sv - command FIFO and dispatch FSM for the vector processing unit (optional VPU_CMDQ_BYPASS_EN)
module vpu_cmd_queue #(
  parameter int DEPTH   = 4,
  parameter int NUM_V   = 8,
  parameter int VW      = 16,
  parameter int BUSY_TO = 4,
  localparam int CW     = 19 + VW * (NUM_V + 1),
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_VPU,
  input  logic [CW-1:0] cmd_in,
  input  logic          flush,
  input  logic          busy,
  output logic          VPU_rdy,
  output logic          go,
  output logic [CW-1:0] cmd_out,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          timeout
);

  localparam int TW = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TO - 1);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, waddr;
  logic [AW:0]   count_q, count_d;
  logic [CW-1:0] cmd_q, cmd_d;
  logic          ovf_q, ovf_d;
  logic          to_flag_q, to_flag_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          full, pop, byp, push_acc, fifo_wr, to_expire;

  assign full = (count_q == FULL_CNT);

  // Handshake decode: pop/bypass decisions, push acceptance and busy-wait expiry
  always_comb begin
    pop = 1'b0;
    byp = 1'b0;
    if (state_q == S_IDLE && !busy) begin
      // A flush in the same cycle cancels the pop so the head is discarded, not issued
      if (count_q != '0 && !flush) begin
        pop = 1'b1;
      end
`ifdef VPU_CMDQ_BYPASS_EN
      else if (count_q == '0 && start_VPU) begin
        byp = 1'b1;
      end
`endif
    end
    // Flush frees every slot, so a push in a flush cycle always has room
    push_acc  = start_VPU && (!full || pop || flush);
    fifo_wr   = push_acc && !byp;
    to_expire = (state_q == S_WAIT_BUSY) && !busy && (tcnt_q == TO_LAST);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (pop || byp) state_d = S_ISSUE;
      S_ISSUE:     state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (busy) begin
          state_d = S_WAIT_DONE;
        end else if (to_expire) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_DONE: if (!busy) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // FSM outputs: go is a pure Moore decode of ISSUE
  always_comb begin
    go = (state_q == S_ISSUE);
  end

  // Next-state values for pointers, occupancy, issued command and sticky flags
  always_comb begin
    cmd_d = cmd_q;
    if (pop) cmd_d = mem_q[rptr_q];
    if (byp) cmd_d = cmd_in;

    waddr = flush ? '0 : wptr_q;
    if (flush) begin
      wptr_d  = fifo_wr ? AW'(1) : '0;
      rptr_d  = '0;
      count_d = (AW + 1)'(fifo_wr);
    end else begin
      wptr_d  = wptr_q + AW'(fifo_wr);
      rptr_d  = rptr_q + AW'(pop);
      count_d = count_q + (AW + 1)'(fifo_wr) - (AW + 1)'(pop);
    end

    ovf_d     = ovf_q | (start_VPU & ~push_acc);
    to_flag_d = to_flag_q | to_expire;

    if (state_q != S_WAIT_BUSY) begin
      tcnt_d = '0;
    end else begin
      tcnt_d = tcnt_q + TW'(1);
    end
  end

  // Control and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      cmd_q     <= '0;
      ovf_q     <= 1'b0;
      to_flag_q <= 1'b0;
      tcnt_q    <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      cmd_q     <= cmd_d;
      ovf_q     <= ovf_d;
      to_flag_q <= to_flag_d;
      tcnt_q    <= tcnt_d;
    end
  end

  // Command storage; contents are qualified by count, so no reset is needed
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem_q[waddr] <= cmd_in;
    end
  end

  assign VPU_rdy  = !full;
  assign cmd_out  = cmd_q;
  assign count    = count_q;
  assign overflow = ovf_q;
  assign timeout  = to_flag_q;

endmodule

// File: tb/tb_vpu_cmd_queue.sv
// tb/tb_vpu_cmd_queue.sv - self-checking bench for vpu_cmd_queue
`timescale 1ns/1ps
module tb_vpu_cmd_queue;

  localparam int DEPTH   = 4;
  localparam int NUM_V   = 8;
  localparam int VW      = 16;
  localparam int BUSY_TO = 4;
  localparam int CW      = 19 + VW * (NUM_V + 1);
  localparam int AW      = $clog2(DEPTH);
  localparam int OBJ_LSB = CW - 19;
`ifdef VPU_CMDQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_VPU = 1'b0;
  logic [CW-1:0] cmd_in = '0;
  logic          flush = 1'b0;
  logic          busy;
  logic          VPU_rdy, go, overflow, timeout;
  logic [CW-1:0] cmd_out;
  logic [AW:0]   count;

  logic busy_force = 1'b0;
  logic busy_model = 1'b0;
  logic model_en   = 1'b0;
  int   busy_len   = 10;
  assign busy = busy_force | busy_model;

  int pass_cnt = 0;
  int total    = 0;
  int go_count = 0;
  logic [4:0] got[$];

  vpu_cmd_queue #(.DEPTH(DEPTH), .NUM_V(NUM_V), .VW(VW), .BUSY_TO(BUSY_TO)) dut (
    .clk(clk), .rst_n(rst_n), .start_VPU(start_VPU), .cmd_in(cmd_in),
    .flush(flush), .busy(busy), .VPU_rdy(VPU_rdy), .go(go),
    .cmd_out(cmd_out), .count(count), .overflow(overflow), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic [4:0] obj;
    logic       busy;
    logic [AW:0] exp_count;
    logic       exp_rdy;
    logic       exp_ovf;
    logic       exp_go;
  } vec_t;
  vec_t vt[6];

  function automatic logic [CW-1:0] mk(input logic [4:0] o);
    logic [CW-1:0] c;
    c = '0;
    c[CW-1] = 1'b1;
    c[CW-2 -: 2] = 2'b10;
    c[OBJ_LSB +: 5] = o;
    c[VW*NUM_V +: VW] = VW'(16'hA000) | VW'(o);
    for (int i = 0; i < NUM_V; i++) c[i*VW +: VW] = VW'(o) + VW'(i * 3);
    return c;
  endfunction

  task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else pass_cnt++;
  endtask

  task automatic step(input logic s, input logic [4:0] o, input logic fl);
    start_VPU = s;
    cmd_in    = mk(o);
    flush     = fl;
    @(posedge clk);
    #1;
    start_VPU = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic wait_go(input string nm);
    int n;
    n = 0;
    while (!go && n < 12) begin
      step(1'b0, 5'd0, 1'b0);
      n++;
    end
    chk(nm, go, 1'b1);
  endtask

  task automatic wait_got(input string nm, input int want, input int bound);
    int n;
    n = 0;
    while (got.size() < want && n < bound) begin
      step(1'b0, 5'd0, 1'b0);
      n++;
    end
    chk(nm, got.size(), want);
  endtask

  // Go monitor: logs the object number of each dispatched command
  always @(negedge clk) begin
    if (rst_n && go) begin
      got.push_back(cmd_out[OBJ_LSB +: 5]);
      go_count++;
    end
  end

  // Matrix-unit model: raise busy on go and hold it for busy_len cycles
  initial begin
    forever begin
      @(negedge clk);
      if (model_en && go) begin
        busy_model = 1'b1;
        repeat (busy_len) @(negedge clk);
        busy_model = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    vt[0] = '{1'b1, 5'd1, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0};
    vt[1] = '{1'b1, 5'd2, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0};
    vt[2] = '{1'b1, 5'd3, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0};
    vt[3] = '{1'b1, 5'd4, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0};
    vt[4] = '{1'b1, 5'd5, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0};
    vt[5] = '{1'b0, 5'd0, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_go", go, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_rdy", VPU_rdy, 1'b1);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_cmd_out", cmd_out, '0);
    rst_n = 1'b1;
    step(1'b0, 5'd0, 1'b0);

    // Single command latency and payload
    model_en = 1'b1;
    busy_len = 10;
    got.delete();
    step(1'b1, 5'd5, 1'b0);
    chk("lat_edge1_go", go, BYP);
    step(1'b0, 5'd0, 1'b0);
    chk("lat_edge2_go", go, !BYP);
    chk("single_cmd_out", cmd_out, mk(5'd5));
    repeat (16) step(1'b0, 5'd0, 1'b0);
    chk("single_go_count", got.size(), 1);
    chk("single_obj", got[0], 5'd5);
    chk("single_count", count, 0);

    // Overflow table with busy held high
    busy_len = 3;
    got.delete();
    for (int i = 0; i < 6; i++) begin
      busy_force = vt[i].busy;
      step(vt[i].start, vt[i].obj, 1'b0);
      chk($sformatf("tbl%0d_count", i), count, vt[i].exp_count);
      chk($sformatf("tbl%0d_rdy", i), VPU_rdy, vt[i].exp_rdy);
      chk($sformatf("tbl%0d_ovf", i), overflow, vt[i].exp_ovf);
      chk($sformatf("tbl%0d_go", i), go, vt[i].exp_go);
    end
    // Push while full, accepted because the head pops in the same cycle
    busy_force = 1'b0;
    step(1'b1, 5'd6, 1'b0);
    chk("full_pop_count", count, 4);
    chk("full_pop_go", go, 1'b1);
    chk("full_pop_obj", cmd_out[OBJ_LSB +: 5], 5'd1);
    wait_got("ovf_drain", 5, 200);
    repeat (10) step(1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      logic [4:0] e;
      e = (i == 4) ? 5'd6 : 5'(i + 1);
      chk($sformatf("ovf_order%0d", i), (i < got.size()) ? got[i] : 5'h1f, e);
    end
    chk("ovf_final_count", count, 0);

    // Three back-to-back pushes, six busy cycles each
    busy_len = 6;
    got.delete();
    step(1'b1, 5'd13, 1'b0);
    step(1'b1, 5'd14, 1'b0);
    step(1'b1, 5'd15, 1'b0);
    wait_got("b2b_gos", 3, 100);
    repeat (12) step(1'b0, 5'd0, 1'b0);
    chk("b2b_total", got.size(), 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("b2b_order%0d", i), (i < got.size()) ? got[i] : 5'h1f, 5'(13 + i));
    chk("b2b_count", count, 0);

    // Busy never rises: timeout then the next command dispatches
    model_en = 1'b0;
    step(1'b1, 5'd7, 1'b0);
    wait_go("to_first_go");
    step(1'b1, 5'd8, 1'b0);
    chk("to_go_one_cycle", go, 1'b0);
    repeat (3) step(1'b0, 5'd0, 1'b0);
    chk("to_not_yet", timeout, 1'b0);
    step(1'b0, 5'd0, 1'b0);
    chk("to_set", timeout, 1'b1);
    chk("to_idle_go", go, 1'b0);
    step(1'b0, 5'd0, 1'b0);
    chk("to_next_go", go, 1'b1);
    chk("to_next_obj", cmd_out[OBJ_LSB +: 5], 5'd8);
    repeat (8) step(1'b0, 5'd0, 1'b0);

    // Flush during WAIT_DONE with a same-cycle push
    model_en = 1'b1;
    busy_len = 10;
    got.delete();
    step(1'b1, 5'd9, 1'b0);
    wait_go("fl_first_go");
    step(1'b1, 5'd10, 1'b0);
    step(1'b1, 5'd11, 1'b0);
    chk("fl_pre_count", count, 2);
    step(1'b1, 5'd12, 1'b1);
    chk("fl_count", count, 1);
    chk("fl_no_abort_go", go, 1'b0);
    wait_got("fl_second_go", 2, 60);
    repeat (14) step(1'b0, 5'd0, 1'b0);
    chk("fl_total", got.size(), 2);
    chk("fl_obj", (got.size() > 1) ? got[1] : 5'h1f, 5'd12);
    chk("fl_final_count", count, 0);

    // Reset during WAIT_BUSY with three queued
    model_en = 1'b0;
    step(1'b1, 5'd20, 1'b0);
    wait_go("rs_first_go");
    step(1'b1, 5'd21, 1'b0);
    step(1'b1, 5'd22, 1'b0);
    step(1'b1, 5'd23, 1'b0);
    chk("rs_pre_count", count, 3);
    rst_n = 1'b0;
    #2;
    chk("rs_go", go, 1'b0);
    chk("rs_count", count, 0);
    chk("rs_rdy", VPU_rdy, 1'b1);
    chk("rs_ovf", overflow, 1'b0);
    chk("rs_timeout", timeout, 1'b0);
    chk("rs_cmd_out", cmd_out, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = go_count;
    repeat (10) step(1'b0, 5'd0, 1'b0);
    chk("rs_no_go", go_count, base);
    step(1'b1, 5'd24, 1'b0);
    chk("rs_lat1_go", go, BYP);
    step(1'b0, 5'd0, 1'b0);
    chk("rs_lat2_go", go, !BYP);
    chk("rs_new_obj", cmd_out[OBJ_LSB +: 5], 5'd24);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/vpu_cmd_queue.md
VPU_CMD_QUEUE -- requirements
Module: vpu_cmd_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning command FIFO entries (power of 2, 2..32).
REQ-002 SHALL have parameter NUM_V, default 8, meaning vertex words per command (1..8).
REQ-003 SHALL have parameter VW, default 16, meaning vertex/RO word width.
REQ-004 SHALL have parameter BUSY_TO, default 4, meaning max cycles to wait for busy after go.
REQ-005 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port start_VPU  in  1  CPU push strobe, one command per high cycle.
REQ-008 SHALL have port cmd_in  in  CW  {fill,obj_type[1:0],obj_color[2:0],op[3:0],code[3:0],obj_num[4:0],RO,V[NUM_V-1..0]}, where CW=19+VW*(NUM_V+1).
REQ-009 SHALL have port flush  in  1  discard all queued, not-yet-issued commands.
REQ-010 SHALL have port busy  in  1  matrix unit busy.
REQ-011 SHALL have port VPU_rdy  out  1  high when not full.
REQ-012 SHALL have port go  out  1  one-cycle dispatch pulse to matrix unit.
REQ-013 SHALL have port cmd_out  out  CW  registered command, stable from go until next go.
REQ-014 SHALL have port count  out  $clog2(DEPTH)+1  queued entries.
REQ-015 SHALL have port overflow  out  1  sticky, push while full.
REQ-016 SHALL have port timeout  out  1  sticky, busy never rose within BUSY_TO.

Function
REQ-017 SHALL store commands in a circular FIFO with wrapping read and write pointers.
REQ-018 SHALL accept a push when count<DEPTH, or when full and a pop occurs the same cycle.
REQ-019 SHALL drop a push while full with no pop, and SHALL set overflow; count SHALL be unchanged.
REQ-020 SHALL implement an FSM with states IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
REQ-021 In IDLE, with count>0 and busy=0, the FSM SHALL pop the head into cmd_out and go to ISSUE.
REQ-022 In ISSUE, go SHALL be 1 for exactly one cycle, then the FSM SHALL go to WAIT_BUSY.
REQ-023 In WAIT_BUSY, busy=1 SHALL move the FSM to WAIT_DONE.
REQ-024 In WAIT_BUSY, BUSY_TO cycles without busy SHALL set timeout and return the FSM to IDLE.
REQ-025 In WAIT_DONE, busy=0 SHALL return the FSM to IDLE.
REQ-026 go SHALL be 0 in all states other than ISSUE.
REQ-027 Latency SHALL be 2 cycles: a push at edge N into an empty queue with the FSM in IDLE and busy=0 gives go=1 in the cycle after edge N+2.
REQ-028 flush SHALL zero count and both pointers.
REQ-029 flush SHALL NOT abort an in-flight command (ISSUE/WAIT_* continue).
REQ-030 When flush and push occur in the same cycle, the push SHALL be retained (count=1).
REQ-031 VPU_rdy SHALL equal (count<DEPTH), combinationally from registered count.

Reset
REQ-032 On rst_n low: go=0, cmd_out=0, count=0, pointers=0, overflow=0, timeout=0, state=IDLE, VPU_rdy=1.
REQ-033 Reset mid-operation SHALL abandon queued and in-flight commands with no further go.
REQ-034 The first go after reset release SHALL come no earlier than 2 cycles after the first push.

Configuration
REQ-035 With macro VPU_CMDQ_BYPASS_EN defined, a push into an empty queue in IDLE with busy=0 SHALL load cmd_out directly from cmd_in, skip the FIFO, and enter ISSUE, giving 1-cycle latency (go in the cycle after edge N+1).
REQ-036 Without VPU_CMDQ_BYPASS_EN, all commands SHALL pass through the FIFO with the REQ-027 latency.
REQ-037 Ordering SHALL be FIFO in both configurations.

Verification
REQ-038 The bench SHALL push 1 command (obj_num=5) with busy low, model busy=1 for 10 cycles after go -> exactly one go, 2 cycles after push (1 with BYPASS), cmd_out obj_num=5.
REQ-039 The bench SHALL hold busy high, push 5 commands with DEPTH=4 -> VPU_rdy=0 after 4th, overflow=1, count=4, 5th lost.
REQ-040 The bench SHALL push 3 commands back-to-back, then busy=1 for 6 cycles per go -> 3 go pulses in push order, count returns to 0.
REQ-041 The bench SHALL issue go with busy held 0 and BUSY_TO=4 -> timeout=1 after 4 cycles, FSM to IDLE, next command dispatched.
REQ-042 The bench SHALL assert flush during WAIT_DONE with 2 queued, plus a same-cycle push -> count=1, current busy cycle completes, 1 further go.
REQ-043 The bench SHALL assert rst_n low during WAIT_BUSY with 3 queued -> all outputs at reset values, no go until a new push.
